// File: rtl/jtbubl_pkg.sv
// Shared offsets and status layout for the JTBUBL main/sound communication port.
package jtbubl_pkg;

  localparam logic [1:0] CMD    = 2'd0;
  localparam logic [1:0] STAT   = 2'd1;
  localparam logic [1:0] NMIDIS = 2'd2;
  localparam logic [1:0] SRST   = 2'd3;

  localparam int unsigned CMD_PEND   = 0;
  localparam int unsigned REPLY_PEND = 1;
  localparam int unsigned OVR        = 2;

  // Field order puts ovr at bit 2 and cmd_pend at bit 0 of the status byte.
  typedef struct packed {
    logic ovr;
    logic reply_pend;
    logic cmd_pend;
  } flags_t;

  function automatic logic [7:0] status_byte(input flags_t f);
    return {5'b0, f};
  endfunction

endpackage

// File: rtl/jtbubl_sndcomm_strobe.sv
// Turns a level chip select into a single-cycle write event and a read-end event on cs fall.
module jtbubl_sndcomm_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic rnw,
  output logic wr_ev,
  output logic rd_end
);

  logic cs_q, valid_q, wr_done_q, rd_q;
  logic acc;

  // cs_q resets high so an access already in progress at reset release is ignored.
  always_comb begin
    acc    = cs & (~cs_q | valid_q);
    wr_ev  = acc & ~rnw & ~wr_done_q;
    rd_end = ~cs & rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q      <= 1'b1;
      valid_q   <= 1'b0;
      wr_done_q <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      cs_q      <= cs;
      valid_q   <= acc;
      wr_done_q <= cs & (wr_done_q | wr_ev);
      rd_q      <= cs & (rd_q | (acc & rnw));
    end
  end

endmodule

// File: rtl/jtbubl_sndcomm.sv
// Main-to-sound CPU command/reply latches, flags, NMI and sound reset.
// Define JTBUBL_SNDCOMM_SNDRST_EN to let main CPU offset-3 writes drive the sound reset.
module jtbubl_sndcomm
  import jtbubl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 240
) (
  input  logic       clk24,
  input  logic       rst_n,
  input  logic       main_cs,
  input  logic [1:0] main_addr,
  input  logic       main_rnw,
  input  logic [7:0] main_dout,
  output logic [7:0] main_din,
  input  logic       snd_cs,
  input  logic [1:0] snd_addr,
  input  logic       snd_rnw,
  input  logic [7:0] snd_dout,
  output logic [7:0] snd_din,
  output logic       snd_nmi_n,
  output logic       snd_rst_n
);

  logic       main_wr, main_rd_end, snd_wr, snd_rd_end;
  logic [1:0] main_addr_q, snd_addr_q;
  logic [7:0] cmd_latch_q, cmd_latch_d, reply_latch_q, reply_latch_d;
  flags_t     flags_q, flags_d;
  logic       nmi_en_q, nmi_en_d;
  logic       nmi_n_q;
  logic       srst_q, srst_d;
  logic [7:0] status;

  jtbubl_sndcomm_strobe u_main_strobe (
    .clk    (clk24),
    .rst_n  (rst_n),
    .cs     (main_cs),
    .rnw    (main_rnw),
    .wr_ev  (main_wr),
    .rd_end (main_rd_end)
  );

  jtbubl_sndcomm_strobe u_snd_strobe (
    .clk    (clk24),
    .rst_n  (rst_n),
    .cs     (snd_cs),
    .rnw    (snd_rnw),
    .wr_ev  (snd_wr),
    .rd_end (snd_rd_end)
  );

`ifdef JTBUBL_SNDCOMM_SNDRST_EN
  localparam logic [7:0] RstLoad = 8'(RST_CYCLES);

  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic       srst_data_q, srst_data_d;
  logic       srst_wr;

  // Line stays low while the count runs, then follows the last written data[0].
  always_comb begin
    srst_wr     = main_wr && (main_addr == SRST);
    srst_data_d = srst_wr ? main_dout[0] : srst_data_q;
    rst_cnt_d   = rst_cnt_q;
    srst_d      = srst_q;
    if (srst_wr && !main_dout[0]) begin
      rst_cnt_d = RstLoad;
      srst_d    = 1'b0;
    end else if (rst_cnt_q > 8'd1) begin
      rst_cnt_d = rst_cnt_q - 8'd1;
      srst_d    = 1'b0;
    end else begin
      rst_cnt_d = 8'd0;
      srst_d    = srst_data_d;
    end
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q   <= RstLoad;
      srst_data_q <= 1'b1;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      srst_data_q <= srst_data_d;
    end
  end
`else
  always_comb srst_d = 1'b1;
`endif

  always_comb begin
    cmd_latch_d   = cmd_latch_q;
    reply_latch_d = reply_latch_q;
    flags_d       = flags_q;
    nmi_en_d      = nmi_en_q;

    // Clears first so that a same-cycle set wins.
    if (snd_rd_end && snd_addr_q == CMD)   flags_d.cmd_pend   = 1'b0;
    if (snd_rd_end && snd_addr_q == STAT)  flags_d.ovr        = 1'b0;
    if (main_rd_end && main_addr_q == CMD) flags_d.reply_pend = 1'b0;

    if (main_wr && main_addr == CMD) begin
      cmd_latch_d      = main_dout;
      flags_d.cmd_pend = 1'b1;
      if (flags_q.cmd_pend) flags_d.ovr = 1'b1;
    end

    if (snd_wr) begin
      unique case (snd_addr)
        CMD: begin
          reply_latch_d      = snd_dout;
          flags_d.reply_pend = 1'b1;
        end
        STAT:    nmi_en_d = 1'b1;
        NMIDIS:  nmi_en_d = 1'b0;
        default: ;
      endcase
    end

    if (!srst_q) begin
      flags_d  = '0;
      nmi_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      main_addr_q   <= CMD;
      snd_addr_q    <= CMD;
      cmd_latch_q   <= 8'd0;
      reply_latch_q <= 8'd0;
      flags_q       <= '0;
      nmi_en_q      <= 1'b0;
      nmi_n_q       <= 1'b1;
      srst_q        <= 1'b0;
    end else begin
      if (main_cs) main_addr_q <= main_addr;
      if (snd_cs)  snd_addr_q  <= snd_addr;
      cmd_latch_q   <= cmd_latch_d;
      reply_latch_q <= reply_latch_d;
      flags_q       <= flags_d;
      nmi_en_q      <= nmi_en_d;
      nmi_n_q       <= ~(flags_q.cmd_pend & nmi_en_q);
      srst_q        <= srst_d;
    end
  end

  always_comb begin
    status = status_byte(flags_q);
    case (main_addr)
      CMD:     main_din = reply_latch_q;
      STAT:    main_din = status;
      default: main_din = 8'hFF;
    endcase
    case (snd_addr)
      CMD:     snd_din = cmd_latch_q;
      STAT:    snd_din = status;
      default: snd_din = 8'hFF;
    endcase
  end

  assign snd_nmi_n = nmi_n_q;
  assign snd_rst_n = srst_q;

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Randomized bench for jtbubl_sndcomm against a transaction-level model of the port.
module tb_jtbubl_sndcomm;

  localparam int unsigned RstCycles = 16;

  logic       clk24 = 1'b0;
  logic       rst_n = 1'b0;
  logic       main_cs = 1'b0, main_rnw = 1'b1, snd_cs = 1'b0, snd_rnw = 1'b1;
  logic [1:0] main_addr = 2'd0, snd_addr = 2'd0;
  logic [7:0] main_dout = 8'd0, snd_dout = 8'd0;
  logic [7:0] main_din, snd_din;
  logic       snd_nmi_n, snd_rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what each CPU should observe once an access has completed.
  logic [7:0] m_cmd = 8'd0, m_reply = 8'd0;
  logic       m_cmd_pend = 1'b0, m_reply_pend = 1'b0, m_ovr = 1'b0, m_nmi_en = 1'b0;

  jtbubl_sndcomm #(.RST_CYCLES(RstCycles)) dut (
    .clk24     (clk24),
    .rst_n     (rst_n),
    .main_cs   (main_cs),
    .main_addr (main_addr),
    .main_rnw  (main_rnw),
    .main_dout (main_dout),
    .main_din  (main_din),
    .snd_cs    (snd_cs),
    .snd_addr  (snd_addr),
    .snd_rnw   (snd_rnw),
    .snd_dout  (snd_dout),
    .snd_din   (snd_din),
    .snd_nmi_n (snd_nmi_n),
    .snd_rst_n (snd_rst_n)
  );

  always #5 clk24 = ~clk24;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {5'b0, m_ovr, m_reply_pend, m_cmd_pend};
  endfunction

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic model_reset();
    m_cmd = 8'd0; m_reply = 8'd0;
    m_cmd_pend = 1'b0; m_reply_pend = 1'b0; m_ovr = 1'b0; m_nmi_en = 1'b0;
  endtask

  // One full access: cs high for one cycle, data sampled mid-cycle, then cs low.
  task automatic main_acc(input logic [1:0] a, input logic rnw, input logic [7:0] d,
                          output logic [7:0] q);
    tick();
    main_cs = 1'b1; main_addr = a; main_rnw = rnw; main_dout = d;
    @(negedge clk24);
    q = main_din;
    tick();
    main_cs = 1'b0;
    tick();
  endtask

  task automatic snd_acc(input logic [1:0] a, input logic rnw, input logic [7:0] d,
                         output logic [7:0] q);
    tick();
    snd_cs = 1'b1; snd_addr = a; snd_rnw = rnw; snd_dout = d;
    @(negedge clk24);
    q = snd_din;
    tick();
    snd_cs = 1'b0;
    tick();
  endtask

  task automatic check_state(input string tag);
    logic exp_nmi;
    tick();
    exp_nmi = !(m_cmd_pend && m_nmi_en);
    main_addr = 2'd1; snd_addr = 2'd0;
    #1;
    check_eq({tag, ".stat"}, main_din, m_status());
    check_eq({tag, ".cmd"}, snd_din, m_cmd);
    main_addr = 2'd0;
    #1;
    check_eq({tag, ".reply"}, main_din, m_reply);
    check_eq({tag, ".nmi"}, snd_nmi_n, exp_nmi);
    check_eq({tag, ".rst"}, snd_rst_n, 1);
  endtask

  // Model-side effects of a main write to the command port.
  task automatic model_main_cmd(input logic [7:0] d);
    if (m_cmd_pend) m_ovr = 1'b1;
    m_cmd = d;
    m_cmd_pend = 1'b1;
  endtask

  initial begin
    logic [7:0] rd, d;
    int op, low_cnt;

    // Reset state
    main_addr = 2'd1; snd_addr = 2'd0;
    repeat (3) tick();
    check_eq("rst.stat", main_din, 8'h00);
    check_eq("rst.cmd", snd_din, 8'h00);
    check_eq("rst.nmi", snd_nmi_n, 1);
    check_eq("rst.srst", snd_rst_n, 0);
    rst_n = 1'b1;
    repeat (RstCycles + 8) tick();
    check_eq("rel.srst", snd_rst_n, 1);

    // NMI timing on a command write
    snd_acc(2'd1, 1'b0, 8'h00, rd); m_nmi_en = 1'b1;
    check_state("en");
    tick();
    main_cs = 1'b1; main_addr = 2'd0; main_rnw = 1'b0; main_dout = 8'h5A;
    @(negedge clk24); check_eq("nmi.c0", snd_nmi_n, 1);
    tick(); main_cs = 1'b0;
    @(negedge clk24); check_eq("nmi.c1", snd_nmi_n, 1);
    tick();
    @(negedge clk24); check_eq("nmi.c2", snd_nmi_n, 0);
    model_main_cmd(8'h5A);
    snd_acc(2'd0, 1'b1, 8'h00, rd); check_eq("t1.rd", rd, 8'h5A); m_cmd_pend = 1'b0;
    check_state("t1");

    // Overrun
    main_acc(2'd0, 1'b0, 8'h11, rd); model_main_cmd(8'h11);
    main_acc(2'd0, 1'b0, 8'h22, rd); model_main_cmd(8'h22);
    snd_acc(2'd1, 1'b1, 8'h00, rd); check_eq("t2.stat", rd, 8'h05); m_ovr = 1'b0;
    snd_acc(2'd0, 1'b1, 8'h00, rd); check_eq("t2.rd", rd, 8'h22); m_cmd_pend = 1'b0;
    check_state("t2");

    // NMI enable after a pending command
    snd_acc(2'd2, 1'b0, 8'h00, rd); m_nmi_en = 1'b0;
    main_acc(2'd0, 1'b0, 8'h33, rd); model_main_cmd(8'h33);
    check_state("t3a");
    snd_acc(2'd1, 1'b0, 8'h00, rd); m_nmi_en = 1'b1;
    check_eq("t3.nmi", snd_nmi_n, 0);
    snd_acc(2'd0, 1'b1, 8'h00, rd); check_eq("t3.rd", rd, 8'h33); m_cmd_pend = 1'b0;
    check_state("t3b");

    // Reply path
    snd_acc(2'd0, 1'b0, 8'hC3, rd); m_reply = 8'hC3; m_reply_pend = 1'b1;
    check_state("t4a");
    main_acc(2'd0, 1'b1, 8'h00, rd); check_eq("t4.rd", rd, 8'hC3); m_reply_pend = 1'b0;
    check_state("t4b");

    // Main write and sound read-end in the same cycle
    main_acc(2'd0, 1'b0, 8'h44, rd); model_main_cmd(8'h44);
    tick();
    snd_cs = 1'b1; snd_addr = 2'd0; snd_rnw = 1'b1;
    @(negedge clk24); check_eq("sim.rd", snd_din, 8'h44);
    tick();
    snd_cs = 1'b0;
    main_cs = 1'b1; main_addr = 2'd0; main_rnw = 1'b0; main_dout = 8'h99;
    tick(); main_cs = 1'b0;
    tick();
    model_main_cmd(8'h99);
    check_state("sim");

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 10);
      d  = 8'($urandom);
      case (op)
        0, 1: begin main_acc(2'd0, 1'b0, d, rd); model_main_cmd(d); end
        2: begin
          main_acc(2'd0, 1'b1, 8'h00, rd); check_eq("r.mrd", rd, m_reply); m_reply_pend = 1'b0;
        end
        3: begin main_acc(2'd1, 1'b1, 8'h00, rd); check_eq("r.mstat", rd, m_status()); end
        4: begin
          snd_acc(2'd0, 1'b1, 8'h00, rd); check_eq("r.srd", rd, m_cmd); m_cmd_pend = 1'b0;
        end
        5: begin snd_acc(2'd1, 1'b1, 8'h00, rd); check_eq("r.sstat", rd, m_status()); m_ovr = 1'b0; end
        6: begin snd_acc(2'd0, 1'b0, d, rd); m_reply = d; m_reply_pend = 1'b1; end
        7: begin snd_acc(2'd1, 1'b0, d, rd); m_nmi_en = 1'b1; end
        8: begin snd_acc(2'd2, 1'b0, d, rd); m_nmi_en = 1'b0; end
        9: begin
          main_acc(2'(1 + d[0]), 1'b0, d, rd);
          main_acc(2'(2 + d[1]), 1'b1, 8'h00, rd); check_eq("r.mff", rd, 8'hFF);
        end
        default: begin snd_acc(2'(2 + d[0]), 1'b1, 8'h00, rd); check_eq("r.sff", rd, 8'hFF); end
      endcase
      check_state("rnd");
    end

    // Reset asserted mid-write, cs still high at release
    tick();
    main_cs = 1'b1; main_addr = 2'd0; main_rnw = 1'b0; main_dout = 8'h77;
    snd_addr = 2'd1;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid.reply", main_din, 8'h00);
    check_eq("mid.stat", snd_din, 8'h00);
    check_eq("mid.nmi", snd_nmi_n, 1);
    model_reset();
    tick();
    rst_n = 1'b1;
    repeat (RstCycles + 8) tick();
    main_cs = 1'b0;
    tick(); tick();
    check_state("mid");

`ifdef JTBUBL_SNDCOMM_SNDRST_EN
    // Sound reset request clears flags and holds the line for the programmed count
    snd_acc(2'd1, 1'b0, 8'h00, rd); m_nmi_en = 1'b1;
    snd_acc(2'd0, 1'b0, 8'h5C, rd); m_reply = 8'h5C; m_reply_pend = 1'b1;
    main_acc(2'd0, 1'b0, 8'hA5, rd); model_main_cmd(8'hA5);
    check_state("sr0");
    tick();
    main_cs = 1'b1; main_addr = 2'd3; main_rnw = 1'b0; main_dout = 8'h00;
    low_cnt = 0;
    for (int i = 1; i < 60; i++) begin
      tick();
      if (i == 1) main_cs = 1'b0;
      if (i == 2) begin main_cs = 1'b1; main_dout = 8'h01; end
      if (i == 3) begin main_cs = 1'b0; main_addr = 2'd1; end
      @(negedge clk24);
      if (snd_rst_n == 1'b0) low_cnt++;
      if (i == 5) begin
        check_eq("sr.stat", main_din, 8'h00);
        check_eq("sr.nmi", snd_nmi_n, 1);
      end
    end
    check_eq("sr.len", low_cnt, RstCycles);
    m_cmd_pend = 1'b0; m_reply_pend = 1'b0; m_ovr = 1'b0; m_nmi_en = 1'b0;
    check_state("sr1");
`else
    // Offset 3 writes have no effect without the reset feature
    main_acc(2'd0, 1'b0, 8'hA5, rd); model_main_cmd(8'hA5);
    main_acc(2'd3, 1'b0, 8'h00, rd);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk24);
      check_eq("nosr.rst", snd_rst_n, 1);
    end
    check_state("nosr");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
